// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole scheduler: FSM state encoding,
// score/miss widths and the hole-position one-hot decode.
package mole_pkg;

   localparam int SCORE_W = 8;
   localparam int MISS_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      GAP,
      UP,
      OVER
   } state_t;

   function automatic logic [7:0] onehot(input logic [2:0] p);
      return 8'b1 << p;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a registered one-cycle tick every DIV clocks (1 ms at CLK_HZ/1000).
module tick_gen #(
   parameter int DIV = 100000
) (
   input  logic CLK100MHZ,
   input  logic CPU_RESETN,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == CW'(DIV - 1)) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + CW'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/mole_sched.sv
// Whack-a-mole game scheduler. Define MOLE_SPEEDUP_EN to shrink the UP window
// by UP_MS/8 every 8 correct hits (floor UP_MS/4). `rand` is a reserved word, so
// the LFSR position input is named rnd.
module mole_sched
   import mole_pkg::*;
#(
   parameter int CLK_HZ   = 100000000,
   parameter int UP_MS    = 1000,
   parameter int GAP_MS   = 250,
   parameter int MAX_MISS = 5
) (
   input  logic               CLK100MHZ,
   input  logic               CPU_RESETN,
   input  logic               start,
   input  logic [2:0]         rnd,
   input  logic [7:0]         hit,
   output logic [7:0]         mole,
   output logic [SCORE_W-1:0] score,
   output logic [MISS_W-1:0]  misses,
   output logic               game_over
);

   localparam int CNT_W = $clog2(((UP_MS > GAP_MS) ? UP_MS : GAP_MS) + 1);

   state_t            state;
   logic              tick;
   logic              start_q;
   logic              start_rise;
   logic [7:0]        hit_q;
   logic [7:0]        hit_edge;
   logic [7:0]        mole_mask;
   logic [2:0]        pos;
   logic [2:0]        spawn_pos;
   logic [CNT_W-1:0]  ms_cnt;
   logic [CNT_W-1:0]  up_win;
   logic              correct;
   logic              wrong;
   logic              timeout;
   logic              miss_inc;
   logic [MISS_W-1:0] miss_next;

   tick_gen #(
      .DIV(CLK_HZ / 1000)
   ) u_tick (
      .CLK100MHZ (CLK100MHZ),
      .CPU_RESETN(CPU_RESETN),
      .tick      (tick)
   );

   // NOTE: every signal is assigned unconditionally at the top of this block,
   // so no path can leave one unassigned and infer a latch.
   always_comb begin
      mole_mask  = onehot(pos);
      start_rise = start & ~start_q;
      hit_edge   = hit & ~hit_q;
      correct    = |(hit_edge & mole_mask);
      wrong      = |(hit_edge & ~mole_mask);
      timeout    = tick && (ms_cnt == up_win - CNT_W'(1));
      miss_inc   = !correct && (wrong || timeout);
      miss_next  = (miss_inc && misses != '1) ? misses + MISS_W'(1) : misses;
      spawn_pos  = (rnd == pos) ? rnd + 3'd1 : rnd;
   end

`ifdef MOLE_SPEEDUP_EN
   localparam int STEP  = UP_MS / 8;
   localparam int FLOOR = (UP_MS / 4 > 0) ? UP_MS / 4 : 1;

   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         up_win <= CNT_W'(UP_MS);
      end else if ((state == IDLE || state == OVER) && start_rise) begin
         up_win <= CNT_W'(UP_MS);
      end else if (state == UP && correct && score != '1 && score[2:0] == 3'd7) begin
         up_win <= (up_win >= CNT_W'(FLOOR + STEP)) ? up_win - CNT_W'(STEP) : CNT_W'(FLOOR);
      end
   end
`else
   assign up_win = CNT_W'(UP_MS);
`endif

   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         state     <= IDLE;
         mole      <= '0;
         score     <= '0;
         misses    <= '0;
         game_over <= 1'b0;
         pos       <= '0;
         hit_q     <= '0;
         // A start held high through reset must not look like a fresh press.
         start_q   <= 1'b1;
         ms_cnt    <= '0;
      end else begin
         hit_q   <= hit;
         start_q <= start;
         case (state)
            IDLE, OVER: begin
               if (start_rise) begin
                  score     <= '0;
                  misses    <= '0;
                  game_over <= 1'b0;
                  mole      <= '0;
                  ms_cnt    <= '0;
                  state     <= GAP;
               end
            end
            GAP: begin
               if (tick) begin
                  if (ms_cnt == CNT_W'(GAP_MS - 1)) begin
                     ms_cnt <= '0;
                     pos    <= spawn_pos;
                     mole   <= onehot(spawn_pos);
                     state  <= UP;
                  end else begin
                     ms_cnt <= ms_cnt + CNT_W'(1);
                  end
               end
            end
            UP: begin
               misses <= miss_next;
               if (correct && score != '1) score <= score + SCORE_W'(1);
               if (tick) ms_cnt <= ms_cnt + CNT_W'(1);
               if (miss_next >= MISS_W'(MAX_MISS)) begin
                  state     <= OVER;
                  game_over <= 1'b1;
                  mole      <= '0;
                  ms_cnt    <= '0;
               end else if (correct || timeout) begin
                  state  <= GAP;
                  mole   <= '0;
                  ms_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mole_sched.sv
// Scoreboard bench for mole_sched: expected mole positions are queued when rnd is
// armed and popped when the mole lights; scalar outputs checked against a model.
module tb_mole_sched;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [2:0] rnd;
   logic [7:0] hit;
   logic [7:0] mole;
   logic [7:0] score;
   logic [3:0] misses;
   logic       game_over;

   int         n_cmp;
   int         n_bad;
   int         n;
   logic [2:0] model_pos;
   logic [7:0] exp_q[$];

   mole_sched #(
      .CLK_HZ  (4000),
      .UP_MS   (4),
      .GAP_MS  (2),
      .MAX_MISS(3)
   ) dut (
      .CLK100MHZ (clk),
      .CPU_RESETN(rst_n),
      .start     (start),
      .rnd       (rnd),
      .hit       (hit),
      .mole      (mole),
      .score     (score),
      .misses    (misses),
      .game_over (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Drive the next spawn position and queue the mole the DUT should light.
   task automatic arm_spawn(input logic [2:0] r);
      logic [2:0] p;
      rnd = r;
      p = (r == model_pos) ? r + 3'd1 : r;
      model_pos = p;
      exp_q.push_back(8'b1 << p);
   endtask

   task automatic wait_mole(output int waited);
      bit found;
      found  = 1'b0;
      waited = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         waited++;
         if (mole != 8'h00) found = 1'b1;
      end
      chk("mole_appears", found, 1);
      chk("sb_depth", exp_q.size(), 1);
      if (exp_q.size() != 0) chk("mole_pos", mole, exp_q.pop_front());
   endtask

   task automatic wait_clear();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (mole == 8'h00) found = 1'b1;
      end
      chk("mole_clears", found, 1);
   endtask

   task automatic pulse(input logic [7:0] v);
      hit = v;
      @(negedge clk);
      hit = 8'h00;
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      model_pos = 3'd0;
      rst_n     = 1'b0;
      start     = 1'b1;
      rnd       = 3'd0;
      hit       = 8'h00;
      cycles(4);
      chk("rst_mole", mole, 8'h00);
      chk("rst_score", score, 0);
      chk("rst_misses", misses, 0);
      chk("rst_over", game_over, 0);

      // start held high through reset: no game may begin
      rst_n = 1'b1;
      cycles(20);
      chk("idle_held_mole", mole, 8'h00);
      chk("idle_held_over", game_over, 0);

      // game 1: first spawn, correct hit
      start = 1'b0;
      arm_spawn(3'd5);
      cycles(2);
      start = 1'b1;
      wait_mole(n);
      chk("gap_len_ok", (n >= 5 && n <= 10), 1);
      arm_spawn(3'd7);
      pulse(8'h20);
      cycles(1);
      chk("hit5_score", score, 1);
      chk("hit5_mole", mole, 8'h00);
      chk("hit5_misses", misses, 0);

      // previous pos 7 and rnd 7 must wrap to hole 0
      wait_mole(n);
      arm_spawn(3'd7);
      pulse(8'h80);
      cycles(1);
      chk("hit7_score", score, 2);
      wait_mole(n);
      arm_spawn(3'd2);
      pulse(8'h01);
      cycles(1);
      chk("hit0_score", score, 3);

      // correct + wrong together, then held high
      wait_mole(n);
      arm_spawn(3'd2);
      hit = 8'h84;
      cycles(4);
      chk("both_score", score, 4);
      chk("both_misses", misses, 0);
      chk("both_mole", mole, 8'h00);
      hit = 8'h00;

      // wrong hit stays in UP, then correct hit
      wait_mole(n);
      pulse(8'h02);
      cycles(1);
      chk("wrong_misses", misses, 1);
      chk("wrong_mole", mole, 8'h08);
      chk("wrong_score", score, 4);
      arm_spawn(3'd6);
      pulse(8'h08);
      cycles(1);
      chk("hit3_score", score, 5);
      chk("hit3_misses", misses, 1);

      // two timeouts reach MAX_MISS
      wait_mole(n);
      arm_spawn(3'd6);
      wait_clear();
      chk("to1_misses", misses, 2);
      chk("to1_over", game_over, 0);
      wait_mole(n);
      wait_clear();
      chk("to2_misses", misses, 3);
      chk("to2_over", game_over, 1);
      chk("to2_score", score, 5);
      pulse(8'hFF);
      cycles(2);
      chk("over_hit_score", score, 5);
      chk("over_hit_misses", misses, 3);
      chk("over_hit_mole", mole, 8'h00);

      // game 2: restart from OVER, three silent windows
      arm_spawn(3'd1);
      start = 1'b0;
      cycles(2);
      start = 1'b1;
      cycles(2);
      chk("g2_score", score, 0);
      chk("g2_misses", misses, 0);
      chk("g2_over", game_over, 0);
      wait_mole(n);
      arm_spawn(3'd1);
      wait_clear();
      wait_mole(n);
      arm_spawn(3'd4);
      wait_clear();
      chk("g2_mid_misses", misses, 2);
      wait_mole(n);
      wait_clear();
      chk("g2_misses_end", misses, 3);
      chk("g2_over_end", game_over, 1);
      chk("g2_mole_end", mole, 8'h00);
      pulse(8'h10);
      cycles(1);
      chk("g2_over_hit", score, 0);

      // game 3: reset mid-game
      arm_spawn(3'd3);
      start = 1'b0;
      cycles(2);
      start = 1'b1;
      wait_mole(n);
      pulse(8'h08);
      rst_n = 1'b0;
      cycles(2);
      chk("midrst_mole", mole, 8'h00);
      chk("midrst_score", score, 0);
      chk("midrst_misses", misses, 0);
      chk("midrst_over", game_over, 0);
      rst_n = 1'b1;
      model_pos = 3'd0;
      cycles(20);
      chk("postrst_mole", mole, 8'h00);
      chk("sb_empty", exp_q.size(), 0);

      // previous pos cleared by reset: rnd 0 must move to hole 1
      arm_spawn(3'd0);
      start = 1'b0;
      cycles(2);
      start = 1'b1;
      wait_mole(n);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/mole_sched.md
MOLE_SCHED -- requirements
Module: mole_sched

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter UP_MS, default 1000, mole-visible window in ms.
REQ-003 Parameter GAP_MS, default 250, dark gap between moles in ms.
REQ-004 Parameter MAX_MISS, default 5, miss count that ends the game.
REQ-005 CLK100MHZ  input  1  sole clock; all logic on rising edge.
REQ-006 CPU_RESETN  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  level; a rising edge begins a game.
REQ-008 rand  input  3  pseudo-random position from the upstream 3-bit LFSR output, sampled once per spawn.
REQ-009 hit  input  8  debounced player buttons, one bit per hole, level.
REQ-010 mole  output  8  one-hot lit hole, all zero when no mole is up.
REQ-011 score  output  8  correct hits, saturating.
REQ-012 misses  output  4  timeouts plus wrong hits.
REQ-013 game_over  output  1  high while in OVER.

Function
REQ-014 The block SHALL run a tick_gen producing a 1-cycle tick every CLK_HZ/1000 cycles; all ms timing counts ticks only.
REQ-015 The FSM SHALL have states IDLE, GAP, UP, OVER.
- IDLE: outputs held; a start rising edge clears score/misses and enters GAP.
- GAP: mole=0; after GAP_MS ticks, spawn, then enter UP.
- UP: mole=onehot(pos); counts UP_MS ticks.
- OVER: game_over=1, mole=0; a start rising edge behaves as in IDLE.
REQ-016 Spawn SHALL set pos=rand, except pos=(rand+1) mod 8 when rand equals the previous pos (wrap 7->0).
REQ-017 Hit detection SHALL use rising edges of hit, registered one cycle (edge = hit & ~hit_q).
REQ-018 In UP, an edge on hit[pos] SHALL increment score (saturating at 255) and enter GAP on the next cycle.
REQ-019 In UP, an edge on any other bit with no edge on hit[pos] SHALL increment misses and remain in UP.
REQ-020 Simultaneous correct and wrong edges SHALL count as a correct hit only.
REQ-021 UP timeout with no correct hit SHALL increment misses and enter GAP.
REQ-022 When misses reaches MAX_MISS, the next state SHALL be OVER regardless of other events; misses SHALL saturate at 15.
REQ-023 Hit edges in IDLE, GAP and OVER SHALL be ignored.
REQ-024 A correct hit and a timeout in the same cycle SHALL count as a hit.

Reset
REQ-025 While CPU_RESETN=0 at a clock edge: state=IDLE, mole=0, score=0, misses=0, game_over=0, previous pos=0, hit_q=0, tick prescaler=0, all ms counters=0.
REQ-026 Reset mid-game SHALL abort immediately with no score retention.

Configuration
REQ-027 With MOLE_SPEEDUP_EN defined, the UP window SHALL shrink by UP_MS/8 after every 8 correct hits, floored at UP_MS/4; without it, the window is fixed at UP_MS.

Structure
REQ-028 Package mole_pkg SHALL hold the state enum, the one-hot decode function and the MISS_W/SCORE_W width constants.
REQ-029 Sub-module tick_gen (parameter DIV, ports CLK100MHZ, CPU_RESETN, tick) SHALL be instantiated once.

Verification
REQ-030 Bench parameters: CLK_HZ=4000 (tick every 4 cycles), UP_MS=4, GAP_MS=2, MAX_MISS=3.
REQ-031 Reset with start=1 held -> mole=0, score=0, misses=0, state IDLE; no game starts until start falls and rises again.
REQ-032 Start, rand=5 at spawn -> mole=8'h20 after 8 cycles of GAP; pulse hit[5] -> score=1, mole=0 within 2 cycles.
REQ-033 Previous pos=7, rand=7 at spawn -> mole=8'h01 (wrap-around avoidance).
REQ-034 No hits for three UP windows -> misses=3, game_over=1, mole=0; further hit edges leave score unchanged.
REQ-035 In UP with pos=2, hit=8'h84 rising together -> score+1, misses unchanged; hold hit[2] high -> no second increment.
